// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime with a 16-bit prescaler, a 64-bit
// mtimecmp, an MTIMEH read shadow and a registered level interrupt.
module bus_timer #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [3:0]              device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    timer_irq_o
);

  typedef enum logic [2:0] {
    RegMtimeL    = 3'd0,
    RegMtimeH    = 3'd1,
    RegMtimeCmpL = 3'd2,
    RegMtimeCmpH = 3'd3,
    RegPrescale  = 3'd4,
    RegStatus    = 3'd5,
    RegRsvd0     = 3'd6,
    RegRsvd1     = 3'd7
  } reg_off_e;

  reg_off_e    reg_off;
  logic        rd_req;
  logic        wr_req;
  logic        err_acc;
  logic [31:0] wmask;
  logic [31:0] rdata_mux;

  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_prescale;

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [63:0] mtimecmp_q;
  logic [15:0] prescale_q;
  logic [15:0] presc_cnt_q;
  logic [31:0] shadow_q;
  logic        tick;

  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

  assign reg_off = reg_off_e'(device_addr_i[4:2]);
  assign rd_req  = device_req_i & ~device_we_i;
  assign wr_req  = device_req_i & device_we_i;
  assign err_acc = (reg_off == RegRsvd0) || (reg_off == RegRsvd1);
  assign wmask   = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                    {8{device_be_i[1]}}, {8{device_be_i[0]}}};

  assign wr_mtime_lo = wr_req && (reg_off == RegMtimeL);
  assign wr_mtime_hi = wr_req && (reg_off == RegMtimeH);
  assign wr_cmp_lo   = wr_req && (reg_off == RegMtimeCmpL);
  assign wr_cmp_hi   = wr_req && (reg_off == RegMtimeCmpH);
  assign wr_prescale = wr_req && (reg_off == RegPrescale);

  assign tick = (presc_cnt_q == prescale_q);

  always_comb begin
    rdata_mux = '0;
    case (reg_off)
      RegMtimeL:    rdata_mux = mtime_q[31:0];
      RegMtimeH:    rdata_mux = shadow_q;
      RegMtimeCmpL: rdata_mux = mtimecmp_q[31:0];
      RegMtimeCmpH: rdata_mux = mtimecmp_q[63:32];
      RegPrescale:  rdata_mux = {16'h0000, prescale_q};
      RegStatus:    rdata_mux = {31'd0, timer_irq_o};
      default:      rdata_mux = '0;
    endcase
  end

  // Any software write to either mtime half freezes the whole counter that cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = merge(mtime_q[31:0], device_wdata_i, wmask);
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = merge(mtime_q[63:32], device_wdata_i, wmask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      timer_irq_o <= (mtime_q >= mtimecmp_q);

      if (wr_prescale || tick) begin
        presc_cnt_q <= '0;
      end else begin
        presc_cnt_q <= presc_cnt_q + 16'd1;
      end

      if (wr_prescale) begin
        prescale_q[7:0]  <= device_be_i[0] ? device_wdata_i[7:0]  : prescale_q[7:0];
        prescale_q[15:8] <= device_be_i[1] ? device_wdata_i[15:8] : prescale_q[15:8];
      end
      if (wr_cmp_lo) begin
        mtimecmp_q[31:0] <= merge(mtimecmp_q[31:0], device_wdata_i, wmask);
      end
      if (wr_cmp_hi) begin
        mtimecmp_q[63:32] <= merge(mtimecmp_q[63:32], device_wdata_i, wmask);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      device_rvalid_o <= 1'b0;
      device_err_o    <= 1'b0;
      device_rdata_o  <= '0;
      shadow_q        <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_err_o    <= device_req_i && err_acc;
      if (device_req_i && err_acc) begin
        device_rdata_o <= '0;
      end else if (rd_req) begin
        device_rdata_o <= rdata_mux;
      end
      // Snapshot the upper half so a following MTIMEH read pairs with this MTIMEL.
      if (rd_req && (reg_off == RegMtimeL)) begin
        shadow_q <= mtime_q[63:32];
      end
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Randomized and directed bench for bus_timer against a behavioural model of
// the register map, prescaler phase and interrupt compare.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bus_timer #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .device_err_o   (err),
    .timer_irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] d,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Behavioural model: mtime ticks whenever the phase since the last
  // prescale restart hits PRESCALE modulo (PRESCALE+1).
  logic [63:0] m_time, m_cmp;
  logic [15:0] m_pre;
  logic [31:0] m_shadow;
  int unsigned m_phase;
  logic        e_rvalid, e_err, e_irq;
  logic [31:0] e_rdata;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    logic [2:0]  o;
    logic [31:0] rv, tmp;
    logic        tk;
    o = addr[4:2];
    if (rst) begin
      m_time = '0; m_cmp = '1; m_pre = '0; m_shadow = '0; m_phase = 0;
      e_rvalid = 1'b0; e_err = 1'b0; e_rdata = '0; e_irq = 1'b0;
    end else begin
      case (o)
        3'd0:    rv = m_time[31:0];
        3'd1:    rv = m_shadow;
        3'd2:    rv = m_cmp[31:0];
        3'd3:    rv = m_cmp[63:32];
        3'd4:    rv = {16'h0000, m_pre};
        3'd5:    rv = {31'd0, e_irq};
        default: rv = '0;
      endcase
      e_rvalid = req;
      e_err    = req && (o >= 3'd6);
      if (e_err) e_rdata = '0;
      else if (req && !we) e_rdata = rv;
      if (req && !we && o == 3'd0) m_shadow = m_time[63:32];
      e_irq = (m_time >= m_cmp);
      tk = ((m_phase % (32'(m_pre) + 1)) == 32'(m_pre));
      m_phase++;
      if (req && we) begin
        case (o)
          3'd0: begin m_time[31:0]  = bmerge(m_time[31:0], wdata, be);  tk = 1'b0; end
          3'd1: begin m_time[63:32] = bmerge(m_time[63:32], wdata, be); tk = 1'b0; end
          3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], wdata, be);
          3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], wdata, be);
          3'd4: begin
            tmp = bmerge({16'h0000, m_pre}, wdata, {2'b00, be[1:0]});
            m_pre = tmp[15:0];
            m_phase = 0;
          end
          default: ;
        endcase
      end
      if (tk) m_time = m_time + 64'd1;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rvalid", 64'(rvalid), 64'(e_rvalid));
      chk("err",    64'(err),    64'(e_err));
      chk("rdata",  64'(rdata),  64'(e_rdata));
      chk("irq",    64'(irq),    64'(e_irq));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic w, input logic [2:0] o, input logic [3:0] b,
                     input logic [31:0] d);
    req = 1'b1; we = w; be = b; wdata = d;
    addr = $urandom; addr[4:2] = o;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] o, input logic [31:0] exp);
    bus(1'b0, o, 4'h0, 32'h0);
    chk({nm, "_rvalid"}, 64'(rvalid), 64'd1);
    chk({nm, "_err"}, 64'(err), 64'(o >= 3'd6));
    chk(nm, 64'(rdata), 64'(exp));
    chk({nm, "_model"}, 64'(e_rdata), 64'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and free-running mtime after release.
    do_reset();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata",  64'(rdata),  64'd0);
    chk("rst_err",    64'(err),    64'd0);
    chk("rst_irq",    64'(irq),    64'd0);
    idle(4);
    rd_chk("mtimel_count", 3'd0, 32'd4);

    // 64-bit wrap and coherent snapshot.
    bus(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
    bus(1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF);
    idle(2);
    rd_chk("wrap_lo", 3'd0, 32'd1);
    rd_chk("wrap_hi", 3'd1, 32'd0);

    // Byte-enable write into mtimecmp and reserved offset response.
    do_reset();
    bus(1'b1, 3'd2, 4'b0010, 32'hAABB_CCDD);
    rd_chk("cmpl_be", 3'd2, 32'hFFFF_CCFF);
    rd_chk("rsvd18", 3'd6, 32'd0);

    // Prescale of 3 and restart on rewrite.
    bus(1'b1, 3'd4, 4'hF, 32'd3);
    bus(1'b1, 3'd1, 4'hF, 32'd0);
    bus(1'b1, 3'd0, 4'hF, 32'd0);
    rd_chk("ps_a", 3'd0, 32'd0);
    rd_chk("ps_b", 3'd0, 32'd0);
    rd_chk("ps_c", 3'd0, 32'd1);
    bus(1'b1, 3'd4, 4'hF, 32'd3);
    idle(2);
    rd_chk("ps_d", 3'd0, 32'd1);
    rd_chk("ps_e", 3'd0, 32'd1);
    rd_chk("ps_f", 3'd0, 32'd2);

    // Interrupt assertion at mtime == mtimecmp and deassertion on rewrite.
    bus(1'b1, 3'd4, 4'hF, 32'd0);
    bus(1'b1, 3'd3, 4'hF, 32'd0);
    bus(1'b1, 3'd2, 4'hF, 32'h20);
    bus(1'b1, 3'd1, 4'hF, 32'd0);
    bus(1'b1, 3'd0, 4'hF, 32'h1E);
    idle(2);
    chk("irq_before", 64'(irq), 64'd0);
    idle(1);
    chk("irq_rise", 64'(irq), 64'd1);
    rd_chk("status", 3'd5, 32'd1);
    bus(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF);
    chk("irq_hold", 64'(irq), 64'd1);
    idle(1);
    chk("irq_fall", 64'(irq), 64'd0);

    // Reset with irq high and requests in flight.
    bus(1'b1, 3'd2, 4'hF, 32'd0);
    idle(2);
    chk("irq_pre_rst", 64'(irq), 64'd1);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    chk("inflight_rvalid", 64'(rvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    chk("rst2_rvalid", 64'(rvalid), 64'd0);
    chk("rst2_rdata",  64'(rdata),  64'd0);
    chk("rst2_err",    64'(err),    64'd0);
    chk("rst2_irq",    64'(irq),    64'd0);
    idle(1);
    chk("post_rst_rvalid", 64'(rvalid), 64'd0);
    rd_chk("cmpl_rst", 3'd2, 32'hFFFF_FFFF);
    rd_chk("cmph_rst", 3'd3, 32'hFFFF_FFFF);

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] o;
      rst = ($urandom_range(0, 249) == 0);
      req = ($urandom_range(0, 99) < 60);
      we  = ($urandom_range(0, 2) == 0);
      be  = 4'($urandom);
      o   = 3'($urandom);
      addr = $urandom; addr[4:2] = o;
      case (o)
        3'd4:       wdata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
        3'd0, 3'd2: wdata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 64)) : $urandom;
        3'd1, 3'd3: wdata = ($urandom_range(0, 3) != 0) ? 32'd0 : $urandom;
        default:    wdata = $urandom;
      endcase
      @(posedge clk); #1;
    end
    rst = 1'b0; req = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, bus data width; only 32 is supported.
REQ-002 SHALL have parameter AddressWidth, default 32, bus address width.
REQ-003 SHALL have port clk_i  input  1  system clock; one clock domain; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port device_req_i  input  1  access request from bus; always accepted, no grant/stall.
REQ-006 SHALL have port device_addr_i  input  AddressWidth  byte address; offset decoded from bits [4:2].
REQ-007 SHALL have port device_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port device_be_i  input  4  byte enables for writes.
REQ-009 SHALL have port device_wdata_i  input  DataWidth  write data.
REQ-010 SHALL have port device_rvalid_o  output  1  response valid, one per request.
REQ-011 SHALL have port device_rdata_o  output  DataWidth  read data.
REQ-012 SHALL have port device_err_o  output  1  error response, qualified by device_rvalid_o.
REQ-013 SHALL have port timer_irq_o  output  1  level timer interrupt to the core's irq_timer input.

Function
REQ-014 Register map (offset: name): 0x00 MTIMEL, 0x04 MTIMEH, 0x08 MTIMECMPL, 0x0C MTIMECMPH, 0x10 PRESCALE (bits [15:0]; upper bits read 0), 0x14 STATUS (bit0 = timer_irq_o, read-only).
REQ-015 Response latency SHALL be exactly 1 cycle: device_rvalid_o = device_req_i registered; back-to-back requests on consecutive cycles each get a response.
REQ-016 Reads SHALL register device_rdata_o on the request cycle; device_rdata_o holds its last value when rvalid is low.
REQ-017 Offsets 0x18/0x1C SHALL respond with device_err_o=1 and rdata 0; writes to them and to STATUS SHALL have no effect; STATUS reads give err 0.
REQ-018 Writes SHALL update only the bytes whose device_be_i bit is set.
REQ-019 A 16-bit prescale counter SHALL count 0..PRESCALE; mtime increments by 1 on the cycle the counter equals PRESCALE, and the counter returns to 0 on that cycle; PRESCALE=0 increments mtime every cycle.
REQ-020 A write to PRESCALE SHALL also clear the prescale counter.
REQ-021 mtime is 64-bit; carry from MTIMEL into MTIMEH in the same cycle; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-022 A write to MTIMEL or MTIMEH SHALL suppress the increment of the whole 64-bit mtime for that cycle; written bytes take wdata, others hold.
REQ-023 Reading MTIMEL SHALL latch mtime[63:32] into a shadow register in the same cycle; reading MTIMEH SHALL return the shadow, not the live value.
REQ-024 timer_irq_o SHALL be registered: next value = (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
REQ-025 Writing mtimecmp above mtime SHALL deassert timer_irq_o one cycle after the write takes effect.

Reset
REQ-026 While rst_i is sampled high: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, PRESCALE=0, prescale counter=0, shadow=0, device_rvalid_o=0, device_err_o=0, device_rdata_o=0, timer_irq_o=0.
REQ-027 A request present in the reset cycle SHALL be dropped (no response); a request issued in the cycle before reset asserts SHALL have no response after reset.

Verification
REQ-028 After reset, PRESCALE=0, read MTIMEL at cycle N -> rvalid at N+1 and rdata equal to the cycle count since reset release (within ±1, exact value defined by the model); err 0.
REQ-029 Write MTIMEL=0xFFFF_FFFF, MTIMEH=0xFFFF_FFFF, PRESCALE=0 -> two increments later mtime reads 0x0000_0000_0000_0001; read MTIMEL then MTIMEH returns a consistent 64-bit snapshot.
REQ-030 PRESCALE=3, mtime=0 -> mtime increments once every 4 cycles; rewriting PRESCALE mid-count restarts the 4-cycle period from 0.
REQ-031 mtimecmp=0x20, mtime=0x1E, PRESCALE=0 -> timer_irq_o rises exactly one cycle after mtime reaches 0x20; STATUS reads 1; writing MTIMECMPL=0xFFFF_FFFF deasserts irq next cycle.
REQ-032 Write MTIMECMPL with be=4'b0010, wdata=0xAABBCCDD from reset value -> MTIMECMPL reads 0xFFFF_CCFF; access to offset 0x18 -> rvalid with err=1, rdata 0.
REQ-033 Assert rst_i for 1 cycle with irq high and request in flight -> next cycle all outputs 0, no stale rvalid, mtimecmp reads all-ones.
